mem_stage_lsu: RTL and testbench
================================

# mem_stage_lsu

Load/store unit for the MEM stage of the RV64 pipeline. It consumes the 3-bit `memControl` size/sign code produced in ID, along with the EX-computed address and store data, and drives a single 64-bit data-memory port through a req/ack handshake. It generates byte strobes and lane-replicated write data, and extracts and sign- or zero-extends load data. It stalls the pipeline while an access is outstanding.

## Interface
Parameters:
- `ACK_TIMEOUT`, 255: maximum number of cycles `dmem_req` is held without `dmem_ack` before the access aborts with `bus_error` (range 1..255).

Ports:
- `clk`  in  1  clock; everything is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ex_valid`  in  1  EX/MEM register holds a valid instruction.
- `mem_read`  in  1  instruction is a load.
- `mem_write`  in  1  instruction is a store.
- `memControl`  in  3  size/sign code: 000 none, 001 BYTE, 010 HALFWORD, 011 WORD, 100 DWORD, 101 BYTE_U, 110 HALFWORD_U, 111 WORD_U.
- `addr`  in  64  effective byte address.
- `store_data`  in  64  rs2 value; only the low bits are used for sizes below DWORD.
- `stall`  out  1  freezes IF..EX/MEM while the access is in progress.
- `load_data`  out  64  extended load result, valid while `load_valid` is high.
- `load_valid`  out  1  one-cycle pulse marking a completed load.
- `store_done`  out  1  one-cycle pulse marking a completed store.
- `misaligned`  out  1  one-cycle pulse; the access was rejected and no bus cycle was issued.
- `bus_error`  out  1  one-cycle pulse marking an ack timeout.
- `dmem_req`  out  1  request, held until acked.
- `dmem_we`  out  1  write enable.
- `dmem_addr`  out  64  `addr` with bits [2:0] cleared.
- `dmem_wdata`  out  64  lane-replicated store data.
- `dmem_wstrb`  out  8  byte strobes.
- `dmem_ack`  in  1  access complete; `dmem_rdata` is valid in the same cycle.
- `dmem_rdata`  in  64  aligned doubleword read data.

## Operation
- FSM states: IDLE, REQ, DONE. The encoding is local to the module.
- Start condition, evaluated in IDLE: `ex_valid & (mem_read ^ mem_write) & memControl != 0`.
  - If `mem_read` and `mem_write` are both high, the cycle is a no-op: no request and no flag.
- Alignment rules:
  - BYTE: any address.
  - HALFWORD: `addr[0]==0`.
  - WORD: `addr[1:0]==0`.
  - DWORD: `addr[2:0]==0`.
  - The U variants follow the rule for their size.
- Start with a misaligned address: pulse `misaligned` in the next cycle, remain in IDLE, `stall` stays low.
- Start with an aligned address: register all request fields, then go to REQ.
- In REQ:
  - On `dmem_ack`, latch the formatted result and go to DONE.
  - Otherwise increment the timeout counter. After `ACK_TIMEOUT` cycles in REQ without an ack, go to DONE with the error flag set.
- In DONE: pulse exactly one of `load_valid`, `store_done`, or `bus_error`, then return to IDLE.
- Strobes, with `o = addr[2:0]`:
  - BYTE: `1<<o`.
  - HALF: `8'h03<<o`.
  - WORD: `8'h0F<<o`.
  - DWORD: `8'hFF`.
- Write data replication:
  - BYTE: byte replicated 8 times.
  - HALF: halfword replicated 4 times.
  - WORD: word replicated 2 times.
  - DWORD: passed through.
  - Stores ignore the U bit (111 behaves as WORD).
- Load extraction: `dmem_rdata >> (o*8)`, truncated to the access size, then sign-extended (codes 001–100) or zero-extended (U codes) to 64 bits.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0. Reset asserted mid-REQ drops `dmem_req` immediately; the data memory tolerates abandoned requests.
- `stall` is combinational: `(IDLE & start & aligned) | REQ`. It is low in DONE.
- Handshake:
  - `dmem_req` and all `dmem_*` outputs are registered and stable from the first REQ cycle until the ack cycle.
  - `dmem_req` drops in the cycle after the ack.
- Minimum access:
  - Cycle 0: IDLE start.
  - Cycle 1: REQ, with ack.
  - Cycle 2: DONE pulse.
  - `stall` is high in cycles 0–1.
- Ack after k REQ cycles: the result pulse comes 1 cycle after the ack, and `stall` is high for k+1 cycles.
- Timeout: `dmem_req` is high for exactly `ACK_TIMEOUT` cycles, then `bus_error` pulses. A late ack arriving in DONE/IDLE is ignored.
- `load_data` holds its value until the next load completes.

## Structure
- The `memControl` encodings live in `parameters.vh` alongside the decoder's `MEM_*` defines. Add `DMEM_STRB_W=8` there.
- Sub-module `lsu_align` (combinational) provides:
  - strobe and write-data generation;
  - load extraction and extension;
  - the alignment check.
- The FSM, timeout counter, and output registers stay in `mem_stage_lsu`.

## Test plan
- LB, `addr=0x1003`, `rdata=0x11223344_8899AABB`: `load_data=0xFFFF_FFFF_FFFF_FF88`. Repeated as LBU: `0x88`.
- SH, `addr=0x2006`, `store_data=0x...BEEF`: `dmem_addr=0x2000`, `wstrb=0xC0`, `wdata=0xBEEF_BEEF_BEEF_BEEF`, `dmem_we=1`, `store_done` one cycle after the ack.
- LW, `addr=0x1002`: `misaligned` pulses in cycle 1, `dmem_req` and `stall` never go high.
- LD with the ack delayed to the 4th REQ cycle: `stall` high for 5 cycles, `load_valid` in cycle 5 with `rdata` passed through.
- `ACK_TIMEOUT=4`, no ack: `dmem_req` high for 4 cycles, then `bus_error` pulses and `stall` clears.
- `rst_n` pulsed low during REQ: `dmem_req` goes low asynchronously and all outputs are 0. A following LWU at `0x1004` with `rdata` upper word `0x8000_0001` returns `0x0000_0000_8000_0001`.

Source files
------------

// File: rtl/mem_stage_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_lsu_pkg
// Description : memControl size/sign encodings, data-port strobe width and
//               size-decode helpers shared by the MEM-stage load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_lsu_pkg;

  // memControl codes as produced by the ID-stage decoder
  localparam logic [2:0] MEM_NONE   = 3'b000;
  localparam logic [2:0] MEM_BYTE   = 3'b001;
  localparam logic [2:0] MEM_HALF   = 3'b010;
  localparam logic [2:0] MEM_WORD   = 3'b011;
  localparam logic [2:0] MEM_DWORD  = 3'b100;
  localparam logic [2:0] MEM_BYTE_U = 3'b101;
  localparam logic [2:0] MEM_HALF_U = 3'b110;
  localparam logic [2:0] MEM_WORD_U = 3'b111;

  // One strobe per byte lane of the 64-bit data port
  localparam int DMEM_STRB_W = 8;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } acc_size_e;

  // Access size of a memControl code; the U bit does not change the size.
  // MEM_NONE never starts an access, so its size is irrelevant.
  function automatic acc_size_e ctrl_size(input logic [2:0] ctrl);
    acc_size_e sz;
    case (ctrl)
      MEM_BYTE, MEM_BYTE_U: sz = SZ_BYTE;
      MEM_HALF, MEM_HALF_U: sz = SZ_HALF;
      MEM_WORD, MEM_WORD_U: sz = SZ_WORD;
      default:              sz = SZ_DWORD;
    endcase
    return sz;
  endfunction

  // Zero-extending load variants are codes 101..111
  function automatic logic ctrl_unsigned(input logic [2:0] ctrl);
    return ctrl[2] & (ctrl[1:0] != 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_lsu_align
// Description : Combinational lane logic for the load/store unit: alignment
//               check, byte strobes, store-data lane replication and load
//               extraction with sign/zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_lsu_align
  import mem_stage_lsu_pkg::*;
(
  // request side (live EX/MEM values)
  input  logic [2:0]             ctrl_i,
  input  logic [2:0]             offset_i,
  input  logic [63:0]            store_data_i,
  output logic                   aligned_o,
  output logic [DMEM_STRB_W-1:0] wstrb_o,
  output logic [63:0]            wdata_o,
  // response side (captured request fields)
  input  logic [2:0]             ld_ctrl_i,
  input  logic [2:0]             ld_offset_i,
  input  logic [63:0]            rdata_i,
  output logic [63:0]            load_data_o
);

  logic [63:0] w_shifted;
  logic        w_uns;

  // Alignment, strobes and replicated write data for the requested size
  always_comb begin
    aligned_o = 1'b1;
    wstrb_o   = 8'hFF;
    wdata_o   = store_data_i;
    case (ctrl_size(ctrl_i))
      SZ_BYTE: begin
        aligned_o = 1'b1;
        wstrb_o   = 8'h01 << offset_i;
        wdata_o   = {8{store_data_i[7:0]}};
      end
      SZ_HALF: begin
        aligned_o = ~offset_i[0];
        wstrb_o   = 8'h03 << offset_i;
        wdata_o   = {4{store_data_i[15:0]}};
      end
      SZ_WORD: begin
        aligned_o = (offset_i[1:0] == 2'b00);
        wstrb_o   = 8'h0F << offset_i;
        wdata_o   = {2{store_data_i[31:0]}};
      end
      default: begin
        aligned_o = (offset_i == 3'b000);
        wstrb_o   = 8'hFF;
        wdata_o   = store_data_i;
      end
    endcase
  end

  // Move the addressed lane down to bit 0, then truncate and extend
  always_comb begin
    w_shifted   = rdata_i >> {ld_offset_i, 3'b000};
    w_uns       = ctrl_unsigned(ld_ctrl_i);
    load_data_o = w_shifted;
    case (ctrl_size(ld_ctrl_i))
      SZ_BYTE: load_data_o = {{56{~w_uns & w_shifted[7]}},  w_shifted[7:0]};
      SZ_HALF: load_data_o = {{48{~w_uns & w_shifted[15]}}, w_shifted[15:0]};
      SZ_WORD: load_data_o = {{32{~w_uns & w_shifted[31]}}, w_shifted[31:0]};
      default: load_data_o = w_shifted;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_lsu
// Description : RV64 MEM-stage load/store unit. Issues one req/ack access on
//               the 64-bit data port per load/store, stalls the pipeline
//               while it is outstanding, and reports completion, misalignment
//               or ack timeout with single-cycle pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ex_valid,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [2:0]             memControl,
  input  logic [63:0]            addr,
  input  logic [63:0]            store_data,
  output logic                   stall,
  output logic [63:0]            load_data,
  output logic                   load_valid,
  output logic                   store_done,
  output logic                   misaligned,
  output logic                   bus_error,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [63:0]            dmem_addr,
  output logic [63:0]            dmem_wdata,
  output logic [DMEM_STRB_W-1:0] dmem_wstrb,
  input  logic                   dmem_ack,
  input  logic [63:0]            dmem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Counter value on the last REQ cycle before the access is abandoned
  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

  logic [1:0]             state_q,      state_d;
  logic [7:0]             cnt_q,        cnt_d;
  logic                   req_q,        req_d;
  logic                   we_q,         we_d;
  logic [63:0]            addr_q,       addr_d;
  logic [63:0]            wdata_q,      wdata_d;
  logic [DMEM_STRB_W-1:0] wstrb_q,      wstrb_d;
  logic [2:0]             ctrl_q,       ctrl_d;
  logic [2:0]             off_q,        off_d;
  logic [63:0]            load_data_q,  load_data_d;
  logic                   load_valid_q, load_valid_d;
  logic                   store_done_q, store_done_d;
  logic                   misalign_q,   misalign_d;
  logic                   bus_err_q,    bus_err_d;

  logic                   w_start;
  logic                   w_aligned;
  logic [DMEM_STRB_W-1:0] w_wstrb;
  logic [63:0]            w_wdata;
  logic [63:0]            w_load_ext;

  // A load or store (never both) with a real size code
  assign w_start = ex_valid & (mem_read ^ mem_write) & (memControl != MEM_NONE);

  mem_stage_lsu_align u_align (
    .ctrl_i       (memControl),
    .offset_i     (addr[2:0]),
    .store_data_i (store_data),
    .aligned_o    (w_aligned),
    .wstrb_o      (w_wstrb),
    .wdata_o      (w_wdata),
    .ld_ctrl_i    (ctrl_q),
    .ld_offset_i  (off_q),
    .rdata_i      (dmem_rdata),
    .load_data_o  (w_load_ext)
  );

  // Next-state logic for the access FSM, timeout counter and output registers
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    ctrl_d       = ctrl_q;
    off_d        = off_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    store_done_d = 1'b0;
    misalign_d   = 1'b0;
    bus_err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_start) begin
          if (w_aligned) begin
            state_d = S_REQ;
            cnt_d   = 8'd0;
            req_d   = 1'b1;
            we_d    = mem_write;
            addr_d  = {addr[63:3], 3'b000};
            wdata_d = w_wdata;
            wstrb_d = w_wstrb;
            ctrl_d  = memControl;
            off_d   = addr[2:0];
          end else begin
            misalign_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (dmem_ack) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          if (we_q) begin
            store_done_d = 1'b1;
          end else begin
            load_valid_d = 1'b1;
            load_data_d  = w_load_ext;
          end
        end else if (cnt_q == TMO_LAST) begin
          state_d   = S_DONE;
          req_d     = 1'b0;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any outstanding request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= 64'd0;
      wdata_q      <= 64'd0;
      wstrb_q      <= '0;
      ctrl_q       <= MEM_NONE;
      off_q        <= 3'd0;
      load_data_q  <= 64'd0;
      load_valid_q <= 1'b0;
      store_done_q <= 1'b0;
      misalign_q   <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      ctrl_q       <= ctrl_d;
      off_q        <= off_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      store_done_q <= store_done_d;
      misalign_q   <= misalign_d;
      bus_err_q    <= bus_err_d;
    end
  end

  // Stall covers the launch cycle and every REQ cycle; held low in reset
  assign stall = rst_n & (((state_q == S_IDLE) & w_start & w_aligned) | (state_q == S_REQ));

  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;
  assign store_done = store_done_q;
  assign misaligned = misalign_q;
  assign bus_error  = bus_err_q;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_wstrb = wstrb_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_lsu
// Description : Self-checking bench for mem_stage_lsu: directed cases plus
//               randomized accesses checked against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_lsu;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, mem_read, mem_write;
  logic [2:0]  memControl;
  logic [63:0] addr, store_data;
  logic        stall, load_valid, store_done, misaligned, bus_error;
  logic [63:0] load_data;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  dmem_wstrb;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_load = 64'd0;

  mem_stage_lsu #(.ACK_TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_valid   (ex_valid),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .memControl (memControl),
    .addr       (addr),
    .store_data (store_data),
    .stall      (stall),
    .load_data  (load_data),
    .load_valid (load_valid),
    .store_done (store_done),
    .misaligned (misaligned),
    .bus_error  (bus_error),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_wstrb (dmem_wstrb),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---- reference model: arithmetic on access size in bytes ----
  function automatic int nbytes(input logic [2:0] c);
    case (c)
      3'd1, 3'd5: return 1;
      3'd2, 3'd6: return 2;
      3'd3, 3'd7: return 4;
      3'd4:       return 8;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [63:0] size_mask(input int n);
    return (n >= 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * n)) - 64'd1);
  endfunction

  function automatic logic [7:0] m_strb(input int n, input int o);
    int m;
    m = (1 << n) - 1;
    return 8'((m << o) & 255);
  endfunction

  function automatic logic [63:0] m_wdata(input int n, input logic [63:0] sd);
    logic [63:0] w;
    w = 64'd0;
    for (int i = 0; i < 8; i += n) w |= (sd & size_mask(n)) << (8 * i);
    return w;
  endfunction

  function automatic logic [63:0] m_load(input logic [2:0] c, input int o, input logic [63:0] rd);
    logic [63:0] v;
    int n;
    n = nbytes(c);
    v = (rd >> (8 * o)) & size_mask(n);
    if (c >= 3'd1 && c <= 3'd4 && v[8*n-1]) v |= ~size_mask(n);
    return v;
  endfunction

  function automatic logic [6:0] flags();
    return {stall, load_valid, store_done, misaligned, bus_error, dmem_req, dmem_we};
  endfunction

  // One complete access; ack_k = REQ cycle carrying the ack, 0 = never ack.
  // Starts at the next clock edge and ends on a falling edge.
  task automatic access(input logic rd, input logic wr, input logic [2:0] ctl,
                        input logic [63:0] a, input logic [63:0] sd,
                        input logic [63:0] rdat, input int ack_k);
    int  n, o;
    bit  go, al, acked;
    n     = nbytes(ctl);
    o     = int'(a[2:0]);
    go    = (rd != wr) && (ctl != 3'd0);
    al    = (n == 0) || ((o % n) == 0);
    acked = (ack_k >= 1) && (ack_k <= TMO);
    step();
    ex_valid = 1'b1; mem_read = rd; mem_write = wr; memControl = ctl;
    addr = a; store_data = sd; dmem_ack = 1'b0; dmem_rdata = rdat;
    @(negedge clk);
    chk("stall_c0", 64'(stall), 64'(go && al));
    if (!go || !al) begin
      step();
      ex_valid = 1'b0;
      @(negedge clk);
      chk("misaligned_pulse", 64'(misaligned), 64'(go && !al));
      chk("no_req", 64'({stall, dmem_req}), 64'd0);
      step();
      @(negedge clk);
      chk("flags_after_reject", 64'(flags() & 7'b0011110), 64'd0);
      return;
    end
    for (int c = 1; c <= TMO; c++) begin
      step();
      dmem_ack = (c == ack_k);
      @(negedge clk);
      chk("req_hi", 64'({dmem_req, stall}), 64'b11);
      chk("req_we", 64'(dmem_we), 64'(wr));
      chk("req_addr", dmem_addr, a & ~64'h7);
      chk("req_strb", 64'(dmem_wstrb), 64'(m_strb(n, o)));
      chk("req_wdata", dmem_wdata, m_wdata(n, sd));
      if (c == ack_k) break;
    end
    // DONE cycle; a late ack here must be ignored
    step();
    dmem_ack = !acked;
    dmem_rdata = ~rdat;
    @(negedge clk);
    chk("done_req_stall", 64'({dmem_req, stall}), 64'd0);
    chk("done_pulses", 64'({load_valid, store_done, bus_error}),
        64'({acked && rd, acked && wr, !acked}));
    if (acked && rd) exp_load = m_load(ctl, o, rdat);
    chk("load_data", load_data, exp_load);
    step();
    ex_valid = 1'b0;
    @(negedge clk);
    chk("idle_flags", 64'(flags() & 7'b1111110), 64'd0);
    chk("load_hold", load_data, exp_load);
    dmem_ack = 1'b0;
  endtask

  initial begin
    logic [63:0] ra;
    logic [2:0]  rc;
    int          op;
    rst_n = 1'b0; ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    memControl = 3'd0; addr = 64'd0; store_data = 64'd0;
    dmem_ack = 1'b0; dmem_rdata = 64'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_flags", 64'(flags()), 64'd0);
    chk("reset_load", load_data, 64'd0);
    chk("reset_bus", dmem_addr | dmem_wdata | 64'(dmem_wstrb), 64'd0);
    rst_n = 1'b1;

    // LB / LBU at offset 3
    access(1, 0, 3'b001, 64'h1003, 64'd0, 64'h11223344_8899AABB, 1);
    chk("lb_value", load_data, 64'hFFFF_FFFF_FFFF_FF88);
    access(1, 0, 3'b101, 64'h1003, 64'd0, 64'h11223344_8899AABB, 1);
    chk("lbu_value", load_data, 64'h88);
    // SH at offset 6
    access(0, 1, 3'b010, 64'h2006, 64'h1234_5678_9ABC_BEEF, 64'd0, 1);
    // LW misaligned
    access(1, 0, 3'b011, 64'h1002, 64'd0, 64'd0, 1);
    // LD with ack on the last allowed REQ cycle
    access(1, 0, 3'b100, 64'h1008, 64'd0, 64'hDEAD_BEEF_CAFE_F00D, 4);
    chk("ld_value", load_data, 64'hDEAD_BEEF_CAFE_F00D);
    // LD with no ack -> timeout
    access(1, 0, 3'b100, 64'h1010, 64'd0, 64'd0, 0);
    // read and write together: no-op
    access(1, 1, 3'b011, 64'h1000, 64'd0, 64'd0, 1);
    // SW with the U code behaves as a word store
    access(0, 1, 3'b111, 64'h3004, 64'hFFFF_FFFF_A5A5_5A5A, 64'd0, 2);

    // reset in the middle of REQ
    step();
    ex_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; memControl = 3'b100;
    addr = 64'h4000; dmem_ack = 1'b0;
    step();
    step();
    #2;
    chk("pre_reset_req", 64'(dmem_req), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_flags", 64'(flags()), 64'd0);
    chk("async_reset_bus", dmem_addr | dmem_wdata | 64'(dmem_wstrb), 64'd0);
    chk("async_reset_load", load_data, 64'd0);
    exp_load = 64'd0;
    @(negedge clk);
    ex_valid = 1'b0;
    rst_n = 1'b1;
    access(1, 0, 3'b111, 64'h1004, 64'd0, 64'h8000_0001_0000_0000, 1);
    chk("lwu_value", load_data, 64'h0000_0000_8000_0001);

    // randomized accesses
    for (int i = 0; i < 60; i++) begin
      op = int'($urandom_range(0, 9));
      rc = 3'($urandom_range(0, 7));
      ra = {$urandom, $urandom};
      if ($urandom_range(0, 2) != 0 && nbytes(rc) > 0)
        ra = ra & ~64'(nbytes(rc) - 1);
      access(op < 5 || op == 9, op >= 5, rc, ra, {$urandom, $urandom},
             {$urandom, $urandom}, int'($urandom_range(0, 4)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
